// File: rtl/neuron_activation.sv
// neuron_activation: two-stage Q32.32 -> Q16.16 saturating rescale and selectable activation with valid/ready flow
module neuron_activation #(
  parameter int FRAC = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] s_sum,
  input  logic [1:0]  mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a_out,
  output logic        sat_flag,
  output logic [15:0] sat_cnt
);
  logic               v1, sat1, ready1, ready2, ovf;
  logic [31:0]        x1, x, y;
  logic [1:0]         m1;
  logic signed [63:0] t;
  logic signed [32:0] xe, hs;
  logic signed [31:0] xs;
  assign ready2   = !out_valid || out_ready;
  assign ready1   = !v1 || ready2;
  assign in_ready = ready1 && !rst;
  // scale: floor shift, then clip anything outside the signed 32-bit range
  always_comb begin
    t   = $signed(s_sum) >>> FRAC;
    ovf = t[63:31] != {33{t[63]}};
    x   = ovf ? (t[63] ? 32'h8000_0000 : 32'h7FFF_FFFF) : t[31:0];
  end
  // activate: hard sigmoid sum kept at 33 bits so extreme inputs cannot wrap
  always_comb begin
    xs = x1;
    xe = {x1[31], x1};
    hs = 33'sh0_8000 + (xe >>> 2);
    y  = m1 == 2'd0 ? x1 :
         m1 == 2'd1 ? (x1[31] ? 32'd0 : x1) :
         m1 == 2'd2 ? (x1[31] ? 32'(xs >>> 3) : x1) :
         hs[32] ? 32'd0 : (hs > 33'sh1_0000 ? 32'h1_0000 : hs[31:0]);
  end
  // pipeline registers, handshake-driven shifting and saturating diagnostic counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1        <= 1'b0;
      sat1      <= 1'b0;
      x1        <= '0;
      m1        <= '0;
      out_valid <= 1'b0;
      a_out     <= '0;
      sat_flag  <= 1'b0;
      sat_cnt   <= '0;
    end else begin
      if (ready1) begin
        v1 <= in_valid;
        if (in_valid) begin
          x1   <= x;
          sat1 <= ovf;
          m1   <= mode;
        end
      end
      if (ready2) begin
        out_valid <= v1;
        if (v1) begin
          a_out    <= y;
          sat_flag <= sat1;
        end
      end
      if (out_valid && out_ready && sat_flag && sat_cnt != 16'hFFFF)
        sat_cnt <= sat_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_neuron_activation.sv
// tb_neuron_activation: directed and randomized checks of neuron_activation against an arithmetic reference model
module tb_neuron_activation;
  logic        clk = 0, rst = 1, in_valid = 0, out_ready = 1;
  logic [63:0] s_sum = '0;
  logic [1:0]  mode = '0;
  logic        in_ready, out_valid, sat_flag;
  logic [31:0] a_out;
  logic [15:0] sat_cnt;
  int          n_tests = 0, n_fail = 0, mcnt = 0, idx;
  bit          acc_last;
  logic [32:0] q[$];
  logic [31:0] hold_a, w;
  logic [63:0] bp[6];

  neuron_activation dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .s_sum(s_sum), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .a_out(a_out), .sat_flag(sat_flag), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [32:0] model(logic [63:0] s, logic [1:0] m);
    longint t, x, y, h, hi, lo;
    bit sat;
    hi  = 2147483647;
    lo  = -hi - 1;
    t   = $signed(s) >>> 16;
    sat = (t > hi) || (t < lo);
    x   = t > hi ? hi : (t < lo ? lo : t);
    h   = 32768 + (x >>> 2);
    case (m)
      2'd0: y = x;
      2'd1: y = x < 0 ? 0 : x;
      2'd2: y = x < 0 ? x >>> 3 : x;
      default: y = h < 0 ? 0 : (h > 65536 ? 65536 : h);
    endcase
    return {sat, y[31:0]};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    logic [32:0] e;
    bit otx;
    #1;
    acc_last = in_valid && in_ready;
    otx = out_valid && out_ready;
    if (otx) begin
      if (q.size() == 0) chk("spurious_out", out_valid, 0);
      else begin
        e = q.pop_front();
        chk("a_out", a_out, e[31:0]);
        chk("sat_flag", sat_flag, e[32]);
        if (e[32] && mcnt < 65535) mcnt++;
      end
    end
    if (acc_last) q.push_back(model(s_sum, mode));
    @(posedge clk);
    #1;
    chk("sat_cnt", sat_cnt, mcnt);
  endtask

  task automatic send1(string tag, logic [63:0] s, logic [1:0] m, logic [31:0] ea, logic es);
    s_sum = s; mode = m; in_valid = 1; out_ready = 1;
    cyc();
    in_valid = 0;
    chk({tag, "_early"}, out_valid, 0);
    cyc();
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_a"}, a_out, ea);
    chk({tag, "_sat"}, sat_flag, es);
    cyc();
  endtask

  initial begin
    #3;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_a_out", a_out, 0);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_sat_cnt", sat_cnt, 0);
    @(posedge clk); #1;
    rst = 0;
    #1 chk("post_rst_in_ready", in_ready, 1);

    send1("identity", 64'h0000_0003_0000_0000, 2'd0, 32'h0003_0000, 0);
    send1("relu_neg", 64'hFFFF_FFFE_0000_0000, 2'd1, 32'h0000_0000, 0);
    send1("leaky_neg", 64'hFFFF_FFFE_0000_0000, 2'd2, 32'hFFFF_C000, 0);
    send1("leaky_pos", 64'h0000_0001_0000_0000, 2'd2, 32'h0001_0000, 0);
    send1("hsig_0", 64'h0, 2'd3, 32'h0000_8000, 0);
    send1("hsig_1", 64'h0000_0001_0000_0000, 2'd3, 32'h0000_C000, 0);
    send1("hsig_4", 64'h0000_0004_0000_0000, 2'd3, 32'h0001_0000, 0);
    send1("hsig_m4", 64'hFFFF_FFFC_0000_0000, 2'd3, 32'h0000_0000, 0);
    send1("sat_max", 64'h7FFF_FFFF_FFFF_FFFF, 2'd0, 32'h7FFF_FFFF, 1);
    chk("sat_cnt_1", sat_cnt, 1);
    send1("sat_min", 64'h8000_0000_0000_0000, 2'd0, 32'h8000_0000, 1);
    chk("sat_cnt_2", sat_cnt, 2);
    send1("hsig_sat", 64'h7FFF_FFFF_FFFF_FFFF, 2'd3, 32'h0001_0000, 1);

    for (int k = 0; k < 6; k++) bp[k] = 64'(k + 1) << 32;
    idx = 0; mode = 0; out_ready = 0; in_valid = 1;
    for (int k = 0; k < 5; k++) begin
      s_sum = bp[idx];
      cyc();
      if (acc_last) idx++;
      if (k == 1) hold_a = a_out;
      if (k > 1) chk("bp_stable", a_out, hold_a);
    end
    chk("bp_accepted", idx, 2);
    chk("bp_in_ready", in_ready, 0);
    out_ready = 1;
    for (int k = 0; k < 6; k++) begin
      in_valid = idx < 6;
      s_sum = bp[idx < 6 ? idx : 5];
      #1 chk("bp_rate", out_valid, 1);
      cyc();
      if (acc_last) idx++;
    end
    in_valid = 0;
    repeat (3) cyc();
    chk("bp_drained", q.size(), 0);

    repeat (400) begin
      w = $urandom;
      case ($urandom_range(0, 2))
        0: s_sum = {$urandom, $urandom};
        1: s_sum = {{16{w[31]}}, w, 16'($urandom)};
        default: s_sum = {{31{w[0]}}, w[0], w};
      endcase
      mode = 2'($urandom);
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      cyc();
    end
    in_valid = 0; out_ready = 1;
    repeat (3) cyc();
    chk("rand_drained", q.size(), 0);

    mode = 0; s_sum = 64'h7FFF_FFFF_FFFF_FFFF; in_valid = 1; out_ready = 1;
    repeat (65540) cyc();
    in_valid = 0;
    repeat (3) cyc();
    chk("sat_stick", sat_cnt, 16'hFFFF);

    out_ready = 0; mode = 0; in_valid = 1;
    s_sum = 64'h0000_0001_0000_0000;
    cyc();
    s_sum = 64'h0000_0002_0000_0000;
    cyc();
    in_valid = 0;
    chk("inflight_valid", out_valid, 1);
    #2 rst = 1; out_ready = 1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sat_cnt", sat_cnt, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_a_out", a_out, 0);
    q.delete();
    mcnt = 0;
    @(posedge clk); #3;
    rst = 0;
    #1;
    chk("after_rst_in_ready", in_ready, 1);
    chk("after_rst_out_valid", out_valid, 0);
    repeat (3) cyc();
    send1("after_rst", 64'h0000_0005_0000_0000, 2'd0, 32'h0005_0000, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
